// File: rtl/stack_pkg.sv
// Shared definitions for the stack CPU operand stack: default geometry
// and the command encoding formed from the controller's {push,pop} strobes.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  // Encoding matches {push,pop} directly so decode is a plain cast.
  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_POP  = 2'b01,
    CMD_PUSH = 2'b10,
    CMD_REPL = 2'b11
  } stack_cmd_e;

  function automatic stack_cmd_e decodeCmd(input logic push, input logic pop);
    return stack_cmd_e'({push, pop});
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x WIDTH register file backing the operand stack. One synchronous
// write port and one asynchronous read port, so the entry below the top
// is available in the same cycle a pop is decoded.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the stack CPU datapath. Holds the stack pointer, a
// registered copy of the top entry, and sticky overflow/underflow flags.
// The top-of-stack register lets tos be a clean flop output while the RAM
// read port only has to supply the next entry down on a pop.
module stack_unit import stack_pkg::*; #(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic             tos_zero,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int AW = $clog2(DEPTH);

  stack_cmd_e       cmd;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic             errOvf_q, errOvf_d;
  logic             errUnf_q, errUnf_d;
  logic             isEmpty, isFull;

  logic             ramWe;
  logic [AW-1:0]    ramWaddr;
  logic [AW-1:0]    ramRaddr;
  logic [WIDTH-1:0] ramRdata;

  assign cmd     = decodeCmd(push, pop);
  assign isEmpty = (sp_q == '0);
  assign isFull  = (sp_q == SPW'(DEPTH));

  // Address arithmetic is done modulo 2**AW, which is exact for every sp
  // value where the address is actually used (including sp == DEPTH).
  assign ramRaddr = sp_q[AW-1:0] - AW'(2);

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ramWe),
    .waddr (ramWaddr),
    .wdata (din),
    .raddr (ramRaddr),
    .rdata (ramRdata)
  );

  // Command decode: next sp/tos, RAM write, and error flag updates; a new
  // error in the same cycle as clr_err overrides the clear.
  always_comb begin
    sp_d     = sp_q;
    tos_d    = tos_q;
    errOvf_d = clr_err ? 1'b0 : errOvf_q;
    errUnf_d = clr_err ? 1'b0 : errUnf_q;
    ramWe    = 1'b0;
    ramWaddr = sp_q[AW-1:0];
    case (cmd)
      CMD_PUSH: begin
        if (!isFull) begin
          ramWe = 1'b1;
          sp_d  = sp_q + SPW'(1);
          tos_d = din;
        end else begin
          errOvf_d = 1'b1;
        end
      end
      CMD_POP: begin
        if (sp_q >= SPW'(2)) begin
          sp_d  = sp_q - SPW'(1);
          tos_d = ramRdata;
        end else if (sp_q == SPW'(1)) begin
          sp_d  = '0;
          tos_d = '0;
        end else begin
          errUnf_d = 1'b1;
        end
      end
      CMD_REPL: begin
        ramWe = 1'b1;
        tos_d = din;
        if (!isEmpty) begin
          ramWaddr = sp_q[AW-1:0] - AW'(1);
        end else begin
          ramWaddr = '0;
          sp_d     = SPW'(1);
          errUnf_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with asynchronous clear of pointer, top and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q     <= '0;
      tos_q    <= '0;
      errOvf_q <= 1'b0;
      errUnf_q <= 1'b0;
    end else begin
      sp_q     <= sp_d;
      tos_q    <= tos_d;
      errOvf_q <= errOvf_d;
      errUnf_q <= errUnf_d;
    end
  end

  assign tos      = tos_q;
  assign tos_zero = (tos_q == '0);
  assign sp       = sp_q;
  assign empty    = isEmpty;
  assign full     = isFull;
  assign err_ovf  = errOvf_q;
  assign err_unf  = errUnf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit with a 4-entry stack so the full and
// overflow paths are reachable in a short table of vectors.
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] tos;
  logic             tos_zero, empty, full, err_ovf, err_unf;
  logic [SPW-1:0]   sp;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clrErr;
    logic [WIDTH-1:0] expTos;
    logic [SPW-1:0]   expSp;
    logic             expEmpty;
    logic             expFull;
    logic             expTosZero;
    logic             expOvf;
    logic             expUnf;
  } vec_t;

  vec_t vecs[$];

  stack_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .clr_err  (clr_err),
    .tos      (tos),
    .tos_zero (tos_zero),
    .sp       (sp),
    .empty    (empty),
    .full     (full),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input string field,
                            input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s %s actual=%0h required=%0h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] eTos,
                             input logic [SPW-1:0] eSp, input logic eEmpty,
                             input logic eFull, input logic eTz,
                             input logic eOvf, input logic eUnf);
    checkField(tag, "tos",      tos,              eTos);
    checkField(tag, "sp",       8'(sp),           8'(eSp));
    checkField(tag, "empty",    {7'd0, empty},    {7'd0, eEmpty});
    checkField(tag, "full",     {7'd0, full},     {7'd0, eFull});
    checkField(tag, "tos_zero", {7'd0, tos_zero}, {7'd0, eTz});
    checkField(tag, "err_ovf",  {7'd0, err_ovf},  {7'd0, eOvf});
    checkField(tag, "err_unf",  {7'd0, err_unf},  {7'd0, eUnf});
  endtask

  // Drive one command away from the edge, then let it be sampled.
  task automatic applyStimulus(input logic p, input logic q,
                               input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    push    = p;
    pop     = q;
    din     = d;
    clr_err = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic addVec(input logic p, input logic q, input logic [7:0] d,
                        input logic c, input logic [7:0] t, input int s,
                        input logic e, input logic f, input logic z,
                        input logic o, input logic u);
    vec_t v;
    v.push = p; v.pop = q; v.din = d; v.clrErr = c;
    v.expTos = t; v.expSp = SPW'(s); v.expEmpty = e; v.expFull = f;
    v.expTosZero = z; v.expOvf = o; v.expUnf = u;
    vecs.push_back(v);
  endtask

  initial begin
    //     push pop din    clr  tos    sp emp full tz ovf unf
    addVec(1, 0, 8'h11, 0, 8'h11, 1, 0, 0, 0, 0, 0);
    addVec(1, 0, 8'h22, 0, 8'h22, 2, 0, 0, 0, 0, 0);
    addVec(1, 0, 8'h33, 0, 8'h33, 3, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h22, 2, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h11, 1, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0);
    addVec(1, 0, 8'h01, 0, 8'h01, 1, 0, 0, 0, 0, 0);
    addVec(1, 0, 8'h02, 0, 8'h02, 2, 0, 0, 0, 0, 0);
    addVec(1, 0, 8'h03, 0, 8'h03, 3, 0, 0, 0, 0, 0);
    addVec(1, 0, 8'h04, 0, 8'h04, 4, 0, 1, 0, 0, 0);
    addVec(1, 0, 8'h05, 0, 8'h04, 4, 0, 1, 0, 1, 0);
    addVec(1, 1, 8'h0A, 0, 8'h0A, 4, 0, 1, 0, 1, 0);
    addVec(0, 0, 8'h00, 1, 8'h0A, 4, 0, 1, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h03, 3, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h02, 2, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h01, 1, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 1);
    addVec(1, 1, 8'h5A, 0, 8'h5A, 1, 0, 0, 0, 0, 1);
    addVec(0, 1, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0, 0);
    addVec(0, 1, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0, 1);
    addVec(0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0, 0);
    addVec(1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    addVec(1, 0, 8'h07, 0, 8'h07, 2, 0, 0, 0, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    addVec(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    addVec(0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0);

    rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
    #12;
    checkOutput("reset", 8'h00, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clrErr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expTos, vecs[i].expSp,
                  vecs[i].expEmpty, vecs[i].expFull, vecs[i].expTosZero,
                  vecs[i].expOvf, vecs[i].expUnf);
    end

    // Mid-cycle asynchronous reset with state and a sticky flag set.
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("preRstUnf", 8'h00, 0, 1, 0, 1, 0, 1);
    applyStimulus(1, 0, 8'h11, 0);
    applyStimulus(1, 0, 8'h22, 0);
    checkOutput("preRstPush", 8'h22, 2, 0, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst", 8'h00, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("postRstPop", 8'h00, 0, 1, 0, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  // Safety bound so the bench always ends even if a wait misbehaves.
  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
